// File: rtl/guess_level_seq.sv
// Level sequencer for the switch-guessing game: arms a masked random target per level,
// judges switch guesses against it, and tracks tries, timeout and the win/lose outcome.
module guess_level_seq #(
    parameter int unsigned NUM_LEVELS  = 3,
    parameter int unsigned BASE_BITS   = 5,
    parameter int unsigned MAX_TRIES   = 3,
    parameter logic [31:0] TIMEOUT_CYC = 32'd0,
    parameter int unsigned SW_W        = BASE_BITS + NUM_LEVELS - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            go,
    input  logic            start,
    input  logic [SW_W-1:0] sw,
    input  logic [SW_W-1:0] rand_in,
    input  logic            cd_done,
    output logic            rand_req,
    output logic            cd_start,
    output logic            beep_req,
    output logic [15:0]     led,
    output logic [3:0]      level,
    output logic [3:0]      tries_left,
    output logic [2:0]      status
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GREET = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_JUDGE = 3'd4;
    localparam logic [2:0] S_MISS  = 3'd5;
    localparam logic [2:0] S_WIN   = 3'd6;
    localparam logic [2:0] S_LOSE  = 3'd7;

    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);

    logic [2:0]      r_state;
    logic [3:0]      r_level;
    logic [3:0]      r_tries;
    logic [SW_W-1:0] r_target;
    logic [SW_W-1:0] r_guess;
    logic [31:0]     r_timer;
    logic            r_entry;

    logic [SW_W-1:0] w_mask;
    logic            w_hit;
    logic            w_last;
    logic            w_count_en;
    logic            w_timeout;

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < SW_W; i++) begin
            w_mask[i] = (i < BASE_BITS + 32'(r_level));
        end
    end

    assign w_hit      = ((r_guess & w_mask) == r_target);
    assign w_last     = (r_level == LAST_LEVEL);
    assign w_count_en = cd_done && (TIMEOUT_CYC != 32'd0);
    // Timer holds the number of counting cycles already spent; the edge that would
    // make it reach TIMEOUT_CYC is the one that moves to MISS.
    assign w_timeout  = w_count_en && (r_timer == TIMEOUT_CYC - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_level  <= '0;
            r_tries  <= '0;
            r_target <= '0;
            r_guess  <= '0;
            r_timer  <= '0;
            r_entry  <= 1'b0;
        end else if (!en) begin
            r_state  <= S_IDLE;
            r_level  <= '0;
            r_tries  <= '0;
            r_target <= '0;
            r_timer  <= '0;
            r_entry  <= 1'b0;
        end else begin
            r_entry <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_GREET;
                S_GREET: begin
                    if (go) begin
                        r_state <= S_ARM;
                        r_level <= '0;
                        r_tries <= TRIES_INIT;
                    end
                end
                S_ARM: begin
                    r_target <= rand_in & w_mask;
                    r_timer  <= '0;
                    r_state  <= S_PLAY;
                end
                S_PLAY: begin
                    if (go) begin
                        r_state <= S_ARM;
                        r_level <= '0;
                        r_tries <= TRIES_INIT;
                    end else if (start && cd_done) begin
                        r_guess <= sw;
                        r_state <= S_JUDGE;
                    end else if (w_timeout) begin
                        r_state <= S_MISS;
                    end else if (w_count_en) begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_JUDGE: begin
                    if (!w_hit) begin
                        r_state <= S_MISS;
                    end else if (w_last) begin
                        r_state <= S_WIN;
                        r_entry <= 1'b1;
                    end else begin
                        r_level <= r_level + 4'd1;
                        r_tries <= TRIES_INIT;
                        r_state <= S_ARM;
                    end
                end
                S_MISS: begin
                    r_tries <= r_tries - 4'd1;
                    if (r_tries == 4'd1) begin
                        r_state <= S_LOSE;
                        r_entry <= 1'b1;
                    end else begin
                        r_timer <= '0;
                        r_state <= S_PLAY;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (go) begin
                        r_state <= S_ARM;
                        r_level <= '0;
                        r_tries <= TRIES_INIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        led = '0;
        if (r_state == S_WIN) begin
            led = '1;
        end else if (r_state >= S_ARM && r_state <= S_MISS) begin
            led = 16'(r_target);
        end
    end

    assign rand_req   = (r_state == S_ARM);
    assign cd_start   = (r_state == S_ARM);
    assign beep_req   = (r_state == S_MISS) ||
                        (((r_state == S_WIN) || (r_state == S_LOSE)) && r_entry);
    assign level      = r_level;
    assign tries_left = r_tries;
    assign status     = r_state;

endmodule

// File: tb/tb_guess_level_seq.sv
// Directed bench for guess_level_seq: a game-level reference model is compared every cycle,
// and literal expectations at key points pin the model to hand-derived values.
module tb_guess_level_seq;

    localparam int NL   = 3;
    localparam int BB   = 5;
    localparam int MT   = 3;
    localparam int TO   = 100;
    localparam int SW_W = BB + NL - 1;

    logic            clk = 1'b0;
    logic            rst, en, go, start, cd_done;
    logic [SW_W-1:0] sw, rand_in;
    logic            rand_req, cd_start, beep_req;
    logic [15:0]     led;
    logic [3:0]      level, tries_left;
    logic [2:0]      status;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_on = 1'b0;

    guess_level_seq #(
        .NUM_LEVELS (NL),
        .BASE_BITS  (BB),
        .MAX_TRIES  (MT),
        .TIMEOUT_CYC(32'd100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .go        (go),
        .start     (start),
        .sw        (sw),
        .rand_in   (rand_in),
        .cd_done   (cd_done),
        .rand_req  (rand_req),
        .cd_start  (cd_start),
        .beep_req  (beep_req),
        .led       (led),
        .level     (level),
        .tries_left(tries_left),
        .status    (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mask(input int l);
        return (1 << (BB + l)) - 1;
    endfunction

    // Game model: phase numbers are the status codes the player sees.
    int m_phase, m_level, m_tries, m_target, m_guess, m_wait;
    bit m_fresh;

    always @(posedge clk) begin
        m_fresh <= 1'b0;
        if (rst) begin
            m_phase <= 0; m_level <= 0; m_tries <= 0; m_target <= 0; m_guess <= 0; m_wait <= 0;
        end else if (!en) begin
            m_phase <= 0; m_level <= 0; m_tries <= 0; m_target <= 0; m_wait <= 0;
        end else begin
            case (m_phase)
                0: m_phase <= 1;
                1: if (go) begin m_phase <= 2; m_level <= 0; m_tries <= MT; end
                2: begin
                    m_target <= int'(rand_in) & mask(m_level);
                    m_wait   <= 0;
                    m_phase  <= 3;
                end
                3: begin
                    if (go) begin
                        m_phase <= 2; m_level <= 0; m_tries <= MT;
                    end else if (start && cd_done) begin
                        m_guess <= int'(sw); m_phase <= 4;
                    end else if (cd_done) begin
                        m_wait <= m_wait + 1;
                        if (m_wait + 1 == TO) m_phase <= 5;
                    end
                end
                4: begin
                    if ((m_guess & mask(m_level)) != m_target) m_phase <= 5;
                    else if (m_level + 1 == NL) begin m_phase <= 6; m_fresh <= 1'b1; end
                    else begin m_level <= m_level + 1; m_tries <= MT; m_phase <= 2; end
                end
                5: begin
                    m_tries <= m_tries - 1;
                    if (m_tries - 1 == 0) begin m_phase <= 7; m_fresh <= 1'b1; end
                    else begin m_phase <= 3; m_wait <= 0; end
                end
                default: if (go) begin m_phase <= 2; m_level <= 0; m_tries <= MT; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [15:0] e_led;
            logic        e_arm, e_beep;
            e_led  = (m_phase == 6) ? 16'hFFFF : (m_phase >= 2 && m_phase <= 5) ? 16'(m_target) : 16'h0;
            e_arm  = (m_phase == 2);
            e_beep = (m_phase == 5) || (m_phase >= 6 && m_fresh);
            check("cycle_outputs",
                  {34'd0, status, level, tries_left, led, rand_req, cd_start, beep_req},
                  {34'd0, 3'(m_phase), 4'(m_level), 4'(m_tries), e_led, e_arm, e_arm, e_beep});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [SW_W-1:0] g);
        sw = g; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; go = 1'b0; start = 1'b0; cd_done = 1'b0;
        sw = '0; rand_in = 7'h65;
        tick();
        chk_on = 1'b1;
        tick();
        check("reset_outputs", {status, level, tries_left, led, rand_req, cd_start, beep_req}, '0);

        rst = 1'b0; tick();
        check("greet_status", status, 3'd1);
        go = 1'b1; tick(); go = 1'b0;
        check("arm_pulses", {status, rand_req, cd_start}, {3'd2, 1'b1, 1'b1});
        tick();
        check("play_status", {status, rand_req, cd_start}, {3'd3, 1'b0, 1'b0});
        check("l0_target", led, 16'h0005);

        // Full win; level-0 guess carries high bits that the mask must ignore.
        cd_done = 1'b1;
        submit(7'h65);
        check("judge_status", status, 3'd4);
        tick();
        check("l1_arm", {status, level, tries_left}, {3'd2, 4'd1, 4'd3});
        tick();
        check("l1_target", led, 16'h0025);
        submit(7'h25); tick(); tick();
        check("l2_target", {level, led}, {4'd2, 16'h0065});
        submit(7'h65); tick();
        check("win_entry", {status, led, beep_req}, {3'd6, 16'hFFFF, 1'b1});
        tick();
        check("win_hold", {status, beep_req}, {3'd6, 1'b0});

        // Lose at level 0.
        go = 1'b1; tick(); go = 1'b0;
        check("restart_from_win", {status, level, tries_left}, {3'd2, 4'd0, 4'd3});
        tick();
        for (int i = 0; i < 3; i++) begin
            submit(7'h00);
            tick();
            check("miss_beep", {status, beep_req}, {3'd5, 1'b1});
            tick();
            check("tries_after_miss", tries_left, 4'(2 - i));
        end
        check("lose_state", {status, led}, {3'd7, 16'h0000});
        submit(7'h05); tick();
        check("lose_ignores_start", {status, tries_left, beep_req}, {3'd7, 4'd0, 1'b0});

        // Early start and timeout.
        cd_done = 1'b0;
        go = 1'b1; tick(); go = 1'b0; tick();
        submit(7'h05);
        check("early_start_ignored", status, 3'd3);
        cd_done = 1'b1;
        repeat (TO - 1) tick();
        check("before_timeout", status, 3'd3);
        tick();
        check("timeout_miss", {status, tries_left}, {3'd5, 4'd3});
        tick();
        check("after_timeout", {status, tries_left}, {3'd3, 4'd2});
        repeat (TO - 1) tick();
        submit(7'h00);
        check("start_beats_timeout", status, 3'd4);
        tick(); tick();
        check("tries_after_judge_miss", {status, tries_left}, {3'd3, 4'd1});

        // Restart in PLAY at level 2.
        go = 1'b1; tick(); go = 1'b0; tick();
        submit(7'h05); tick(); tick();
        submit(7'h25); tick(); tick();
        check("reached_l2", {status, level}, {3'd3, 4'd2});
        go = 1'b1; tick(); go = 1'b0;
        check("restart_in_play", {status, level, tries_left}, {3'd2, 4'd0, 4'd3});
        tick();

        // Disable during JUDGE.
        submit(7'h05);
        en = 1'b0; tick();
        check("disable_to_idle", {status, level, tries_left, led}, {3'd0, 4'd0, 4'd0, 16'h0});
        en = 1'b1; tick();
        check("reenable_greet", status, 3'd1);

        // Reset during MISS.
        go = 1'b1; tick(); go = 1'b0; tick();
        submit(7'h00); tick();
        check("in_miss", status, 3'd5);
        rst = 1'b1; tick();
        check("reset_in_miss", {status, level, tries_left, led, rand_req, cd_start, beep_req}, '0);
        rst = 1'b0; tick();
        check("greet_after_reset", status, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
